press_decoder: RTL
==================

PRESS_DECODER -- requirements
Module: press_decoder

Interface
REQ-001 SHALL provide parameter c_LONG_LIMIT, default 12500000, consecutive pressed cycles that classify a long press (500 ms at 25 MHz).
REQ-002 SHALL provide parameter c_DCLICK_LIMIT, default 6250000, maximum released-gap cycles between two presses that form a double click (250 ms at 25 MHz).
REQ-003 SHALL provide port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL provide port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port i_Switch  input  1  debounced switch level, 1 = pressed, synchronous to CLK.
REQ-006 SHALL provide port o_Short  output  1  one-cycle pulse for a short press.
REQ-007 SHALL provide port o_Long  output  1  one-cycle pulse when a press reaches c_LONG_LIMIT.
REQ-008 SHALL provide port o_Double  output  1  one-cycle pulse for a double click.
REQ-009 SHALL provide port o_Held  output  1  level, high while a long press remains held.
REQ-010 SHALL provide port o_Busy  output  1  level, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, PRESSED, WAIT_GAP, SECOND, LONG_HELD with one 24-bit cycle counter; all outputs registered.
REQ-012 IDLE: counter held at 0; i_Switch=1 -> PRESSED, counter=1.
REQ-013 PRESSED: counter +1 per cycle while i_Switch=1; when counter reaches c_LONG_LIMIT with i_Switch=1 -> LONG_HELD and o_Long pulses in the following cycle.
REQ-014 PRESSED: i_Switch=0 before limit -> WAIT_GAP with counter=1 (double-click build) or IDLE with o_Short pulse next cycle.
REQ-015 WAIT_GAP: counter +1 per released cycle; i_Switch=1 while counter < c_DCLICK_LIMIT -> SECOND, counter=1; counter reaching c_DCLICK_LIMIT -> IDLE, o_Short pulse next cycle.
REQ-016 SECOND: release before c_LONG_LIMIT -> IDLE, o_Double pulse next cycle; reaching c_LONG_LIMIT -> LONG_HELD, o_Short and o_Long pulse together next cycle.
REQ-017 LONG_HELD: o_Held=1; i_Switch=0 -> IDLE, o_Held=0 next cycle, no other pulse.
REQ-018 Press lasting exactly c_LONG_LIMIT cycles SHALL be long; c_LONG_LIMIT-1 cycles SHALL be short.
REQ-019 Gap of exactly c_DCLICK_LIMIT-1 released cycles SHALL yield SECOND; c_DCLICK_LIMIT cycles SHALL yield short.
REQ-020 At most one of o_Short/o_Double SHALL pulse per gesture; pulses SHALL never exceed one cycle.
REQ-021 Counter SHALL saturate, never wrap; parameters SHALL be in 2..16777215.

Reset
REQ-022 RST_N=0 SHALL immediately force IDLE, counter 0, all outputs 0, regardless of in-progress gesture.
REQ-023 Gesture interrupted by reset SHALL produce no pulse; i_Switch=1 at first edge after RST_N rises SHALL start a new press.

Configuration
REQ-024 Macro PRESS_DECODER_DCLICK_EN defined: WAIT_GAP and SECOND exist, behaviour per REQ-014..016.
REQ-025 Macro undefined: short release goes directly to IDLE with o_Short pulse next cycle; o_Double tied 0; c_DCLICK_LIMIT ignored.

Verification (c_LONG_LIMIT=8, c_DCLICK_LIMIT=5, macro defined unless noted)
REQ-026 Press 3 cycles, release 10 -> single o_Short pulse 6 cycles after release edge (5-cycle gap timeout +1); no o_Long/o_Double.
REQ-027 Press 3, release 2, press 3, release -> one o_Double pulse the cycle after second release; no o_Short.
REQ-028 Press 7 vs. press 8 -> 7: o_Short after gap timeout; 8: o_Long one cycle after 8th pressed cycle, o_Held high until release+1.
REQ-029 Press 3, release 4, press 3 vs. release 5 -> 4: o_Double; 5: o_Short then new gesture begins.
REQ-030 Pull RST_N low in PRESSED after 5 cycles, switch held -> outputs 0 immediately; after RST_N rises, o_Long 8 cycles later.
REQ-031 Macro undefined: press 3, release -> o_Short the cycle after release; o_Double never asserts.

Source files
------------

// File: rtl/press_decoder.sv
// press_decoder: classifies a debounced switch into short, long and
// double-click gestures. Each gesture output is a registered single-cycle
// pulse; o_Held and o_Busy are registered levels.
// Optional feature macro: PRESS_DECODER_DCLICK_EN enables double-click
// detection (WAIT_GAP/SECOND states). Without it, every short press reports
// immediately on release and o_Double stays low.
module press_decoder #(
    parameter int unsigned c_LONG_LIMIT   = 12500000,
    parameter int unsigned c_DCLICK_LIMIT = 6250000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_Switch,
    output logic o_Short,
    output logic o_Long,
    output logic o_Double,
    output logic o_Held,
    output logic o_Busy
);

    // Both limits must fit the 24-bit counter and allow at least one step.
    if (c_LONG_LIMIT < 32'd2 || c_LONG_LIMIT > 32'd16777215) begin : g_bad_long
        $error("press_decoder: c_LONG_LIMIT out of range 2..16777215");
    end
    if (c_DCLICK_LIMIT < 32'd2 || c_DCLICK_LIMIT > 32'd16777215) begin : g_bad_dclick
        $error("press_decoder: c_DCLICK_LIMIT out of range 2..16777215");
    end

    localparam logic [23:0] LP_LONG = 24'(c_LONG_LIMIT);
`ifdef PRESS_DECODER_DCLICK_EN
    localparam logic [23:0] LP_DCLICK = 24'(c_DCLICK_LIMIT);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_WAIT_GAP,
        ST_SECOND,
        ST_LONG_HELD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic [23:0] w_cnt_inc;
    logic        w_short_nxt;
    logic        w_long_nxt;
    logic        w_double_nxt;
    logic        r_Short;
    logic        r_Long;
    logic        r_Double;
    logic        r_Held;
    logic        r_Busy;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 24'd1;

    // Next-state, next-count and pulse decode; a limit is "reached" on the
    // edge whose sampled input would bring the count up to it.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_Switch) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = 24'd1;
                end
            end
            ST_PRESSED: begin
                if (i_Switch) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= LP_LONG) begin
                        w_state_nxt = ST_LONG_HELD;
                        w_long_nxt  = 1'b1;
                    end
                end else begin
`ifdef PRESS_DECODER_DCLICK_EN
                    w_state_nxt = ST_WAIT_GAP;
                    w_cnt_nxt   = 24'd1;
`else
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_short_nxt = 1'b1;
`endif
                end
            end
`ifdef PRESS_DECODER_DCLICK_EN
            ST_WAIT_GAP: begin
                // The registered count is always below the gap limit here.
                if (i_Switch) begin
                    w_state_nxt = ST_SECOND;
                    w_cnt_nxt   = 24'd1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= LP_DCLICK) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_short_nxt = 1'b1;
                    end
                end
            end
            ST_SECOND: begin
                if (i_Switch) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= LP_LONG) begin
                        w_state_nxt = ST_LONG_HELD;
                        w_short_nxt = 1'b1;
                        w_long_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                    w_double_nxt = 1'b1;
                end
            end
`endif
            ST_LONG_HELD: begin
                if (!i_Switch) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset abandons any gesture silently.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_Short  <= 1'b0;
            r_Long   <= 1'b0;
            r_Double <= 1'b0;
            r_Held   <= 1'b0;
            r_Busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_Short  <= w_short_nxt;
            r_Long   <= w_long_nxt;
            r_Double <= w_double_nxt;
            r_Held   <= (w_state_nxt == ST_LONG_HELD);
            r_Busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_Short  = r_Short;
    assign o_Long   = r_Long;
    assign o_Double = r_Double;
    assign o_Held   = r_Held;
    assign o_Busy   = r_Busy;

endmodule
